apb_timer: RTL and testbench

APB_TIMER -- requirements
Module: apb_timer

---
 rtl/apb_timer_pkg.sv | 38 +++
 rtl/apb_if.sv | 25 ++
 rtl/apb_timer_prescaler.sv | 28 ++
 rtl/apb_timer.sv | 145 ++++++++++++++
 tb/tb_apb_timer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: register offsets, CTRL layout, APB FSM states and byte-strobe helper.
package apb_timer_pkg;

    localparam logic [4:0] OFFS_MTIME_LO    = 5'h00;
    localparam logic [4:0] OFFS_MTIME_HI    = 5'h04;
    localparam logic [4:0] OFFS_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] OFFS_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] OFFS_CTRL        = 5'h10;
    localparam logic [4:0] OFFS_STATUS      = 5'h14;

    localparam int unsigned PRESC_W = 8;

    typedef struct packed {
        logic [PRESC_W-1:0] presc;
        logic               en;
    } ctrl_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Merge new_val into old_val for every byte lane whose strobe is set.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_if.sv
// APB: register-access bus as delivered by the OBI-to-APB bridge.
interface APB #(
    parameter int unsigned ADDR_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [2:0]        pprot;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport Master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport Slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_timer_prescaler.sv
// apb_timer_prescaler: emits one tick every presc_i+1 enabled cycles.
module apb_timer_prescaler
    import apb_timer_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic               clr_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == presc_i);

    // Count enabled cycles, wrapping to 0 on each tick or on a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i || tick_o) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/apb_timer.sv
// apb_timer: APB-mapped 64-bit machine timer (MTIME/MTIMECMP) with registered interrupt.
// Define APB_TIMER_PRESCALER_EN to divide the tick rate by CTRL.PRESC+1.
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter logic [63:0] RST_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic clk_i,
    input  logic rst_ni,
    APB.Slave    apb_i,
    output logic timer_irq_o
);

    // state_q holds the bus phase of the previous cycle; state is the phase of
    // the current cycle, so a transfer completes in setup + access with no wait.
    apb_state_e        state_q, state;
    logic [ADDR_W-1:0] paddr;
    logic [4:0]        offs;
    logic              access, err, wr_en, rd_en;
    logic [31:0]       rdata;
    logic [63:0]       mtime_q, mtimecmp_q;
    logic [31:0]       shadow_q;
    ctrl_t             ctrl_q;
    logic              irq_q;
    logic              tick;

    assign paddr = apb_i.paddr;
    assign offs  = paddr[4:0];

    // Current bus phase from the previous phase and the bus controls.
    always_comb begin
        state = IDLE;
        case (state_q)
            IDLE:    if (apb_i.psel && !apb_i.penable) state = SETUP;
            SETUP:   state = ACCESS;
            ACCESS:  if (apb_i.psel && !apb_i.penable) state = SETUP;
            default: state = IDLE;
        endcase
    end

    // Phase register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state;
        end
    end

    assign access = (state == ACCESS);
    assign err    = (offs[1:0] != 2'b00) || (offs > OFFS_STATUS) ||
                    (apb_i.pwrite && (offs == OFFS_STATUS));
    assign wr_en  = access && apb_i.pwrite && !err;
    assign rd_en  = access && !apb_i.pwrite && !err;

    assign apb_i.pready  = access;
    assign apb_i.pslverr = access && err;
    assign apb_i.prdata  = rd_en ? rdata : '0;

    // Read-data multiplexer.
    always_comb begin
        rdata = '0;
        case (offs)
            OFFS_MTIME_LO:    rdata = mtime_q[31:0];
            OFFS_MTIME_HI:    rdata = shadow_q;
            OFFS_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
            OFFS_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
            OFFS_CTRL:        rdata = {16'h0000, ctrl_q.presc, 7'h00, ctrl_q.en};
            OFFS_STATUS:      rdata = {31'h0, irq_q};
            default:          rdata = '0;
        endcase
    end

`ifdef APB_TIMER_PRESCALER_EN
    logic ctrl_wr;
    assign ctrl_wr = wr_en && (offs == OFFS_CTRL);

    apb_timer_prescaler u_prescaler (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (ctrl_q.en),
        .presc_i (ctrl_q.presc),
        .clr_i   (ctrl_wr),
        .tick_o  (tick)
    );
`else
    assign tick = ctrl_q.en;
`endif

    // MTIME counter: a bus write to either half wins over that cycle's tick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q <= '0;
        end else if (wr_en && (offs == OFFS_MTIME_LO)) begin
            mtime_q[31:0] <= apply_strb(mtime_q[31:0], apb_i.pwdata, apb_i.pstrb);
        end else if (wr_en && (offs == OFFS_MTIME_HI)) begin
            mtime_q[63:32] <= apply_strb(mtime_q[63:32], apb_i.pwdata, apb_i.pstrb);
        end else if (tick) begin
            mtime_q <= mtime_q + 64'd1;
        end
    end

    // Shadow of MTIME[63:32], captured by a MTIME_LO read for atomic LO-then-HI reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
        end else if (rd_en && (offs == OFFS_MTIME_LO)) begin
            shadow_q <= mtime_q[63:32];
        end
    end

    // MTIMECMP and CTRL register writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtimecmp_q <= RST_CMP;
            ctrl_q     <= '0;
        end else if (wr_en) begin
            if (offs == OFFS_MTIMECMP_LO) begin
                mtimecmp_q[31:0] <= apply_strb(mtimecmp_q[31:0], apb_i.pwdata, apb_i.pstrb);
            end
            if (offs == OFFS_MTIMECMP_HI) begin
                mtimecmp_q[63:32] <= apply_strb(mtimecmp_q[63:32], apb_i.pwdata, apb_i.pstrb);
            end
            if (offs == OFFS_CTRL) begin
                if (apb_i.pstrb[0]) ctrl_q.en <= apb_i.pwdata[0];
`ifdef APB_TIMER_PRESCALER_EN
                if (apb_i.pstrb[1]) ctrl_q.presc <= apb_i.pwdata[15:8];
`endif
            end
        end
    end

    // Registered compare: interrupt level follows MTIME >= MTIMECMP one cycle later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (mtime_q >= mtimecmp_q);
        end
    end

    assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: directed self-checking bench for apb_timer.
module tb_apb_timer;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic timer_irq;
    int   checks = 0;
    int   errors = 0;
    int   k;

    APB #(.ADDR_W(32)) apb ();

    apb_timer #(
        .ADDR_W  (32),
        .RST_CMP (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .apb_i       (apb),
        .timer_irq_o (timer_irq)
    );

    always #5 clk_i = ~clk_i;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Tasks start and end 1 ns after a rising edge, so calls run back-to-back.
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic exp_err, input string tag);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
        apb.paddr = addr; apb.pwdata = data; apb.pstrb = strb;
        #1;
        check1({tag, "_setup_pready"}, apb.pready, 1'b0);
        @(posedge clk_i); #1;
        apb.penable = 1'b1;
        #1;
        check1({tag, "_pready"}, apb.pready, 1'b1);
        check1({tag, "_pslverr"}, apb.pslverr, exp_err);
        @(posedge clk_i); #1;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic exp_err, input string tag);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = addr; apb.pwdata = 32'hDEAD_BEEF; apb.pstrb = 4'h0;
        #1;
        check1({tag, "_setup_pready"}, apb.pready, 1'b0);
        check32({tag, "_setup_prdata"}, apb.prdata, 32'h0);
        @(posedge clk_i); #1;
        apb.penable = 1'b1;
        #1;
        check1({tag, "_pready"}, apb.pready, 1'b1);
        check1({tag, "_pslverr"}, apb.pslverr, exp_err);
        check32({tag, "_prdata"}, apb.prdata, exp_data);
        @(posedge clk_i); #1;
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = '0; apb.pwdata = '0; apb.pstrb = '0; apb.pprot = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check1("rst_irq", timer_irq, 1'b0);
        check1("rst_pready", apb.pready, 1'b0);
        check1("rst_pslverr", apb.pslverr, 1'b0);
        check32("rst_prdata", apb.prdata, 32'h0);
        rst_ni = 1'b1;

        // Reset values of every register.
        apb_read(32'h00, 32'h0000_0000, 1'b0, "r_mtime_lo");
        apb_read(32'h04, 32'h0000_0000, 1'b0, "r_mtime_hi");
        apb_read(32'h08, 32'hFFFF_FFFF, 1'b0, "r_cmp_lo");
        apb_read(32'h0C, 32'hFFFF_FFFF, 1'b0, "r_cmp_hi");
        apb_read(32'h10, 32'h0000_0000, 1'b0, "r_ctrl");
        apb_read(32'h14, 32'h0000_0000, 1'b0, "r_status");

        // 64-bit wrap: FFFF_FFFF_FFFF_FFFE -> ...FF -> 0 -> 1.
        apb_write(32'h00, 32'hFFFF_FFFE, 4'hF, 1'b0, "w_wrap_lo");
        apb_write(32'h04, 32'hFFFF_FFFF, 4'hF, 1'b0, "w_wrap_hi");
        apb_write(32'h10, 32'h0000_0001, 4'hF, 1'b0, "w_wrap_ctrl");
        repeat (2) @(posedge clk_i);
        #1;
        apb_read(32'h00, 32'h0000_0001, 1'b0, "wrap_lo");
        apb_read(32'h04, 32'h0000_0000, 1'b0, "wrap_hi");

        // Partial-strobe MTIME_LO write while ticking: write wins, increment dropped.
        apb_write(32'h10, 32'h0000_0000, 4'hF, 1'b0, "w_stop1");
        apb_write(32'h00, 32'hAABB_CCDD, 4'hF, 1'b0, "w_strb_lo0");
        apb_write(32'h04, 32'h0000_0000, 4'hF, 1'b0, "w_strb_hi0");
        apb_write(32'h10, 32'h0000_0001, 4'hF, 1'b0, "w_strb_run");
        apb_write(32'h00, 32'h1234_5678, 4'b0011, 1'b0, "w_strb_lo");
        apb_write(32'h10, 32'h0000_0000, 4'hF, 1'b0, "w_stop2");
        apb_read(32'h00, 32'hAABB_567A, 1'b0, "strb_lo");
        apb_read(32'h04, 32'h0000_0000, 1'b0, "strb_hi");

        // Interrupt rises one cycle after MTIME reaches 0x10.
        apb_write(32'h00, 32'h0, 4'hF, 1'b0, "w_irq_lo");
        apb_write(32'h04, 32'h0, 4'hF, 1'b0, "w_irq_hi");
        apb_write(32'h0C, 32'h0, 4'hF, 1'b0, "w_irq_cmp_hi");
        apb_write(32'h08, 32'h10, 4'hF, 1'b0, "w_irq_cmp_lo");
        check1("irq_before_run", timer_irq, 1'b0);
        apb_write(32'h10, 32'h1, 4'hF, 1'b0, "w_irq_run");
        k = 101;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk_i); #1;
            if (timer_irq === 1'b1) begin
                k = i;
                break;
            end
        end
        check32("irq_rise_cycle", k, 32'd17);
        apb_read(32'h14, 32'h0000_0001, 1'b0, "status_irq");
        apb_write(32'h0C, 32'h1, 4'hF, 1'b0, "w_irq_cmp_hi1");
        check1("irq_hold_after_cmp", timer_irq, 1'b1);
        @(posedge clk_i); #1;
        check1("irq_fall_after_cmp", timer_irq, 1'b0);
        apb_write(32'h10, 32'h0, 4'hF, 1'b0, "w_stop3");

        // CTRL=0x0301: prescaled (every 4 cycles) or every cycle with PRESC ignored.
        apb_write(32'h00, 32'h0, 4'hF, 1'b0, "w_p_lo");
        apb_write(32'h04, 32'h0, 4'hF, 1'b0, "w_p_hi");
        apb_write(32'h10, 32'h0000_0301, 4'hF, 1'b0, "w_p_ctrl");
        repeat (10) @(posedge clk_i);
        #1;
`ifdef APB_TIMER_PRESCALER_EN
        apb_read(32'h00, 32'd2, 1'b0, "presc_t11");
        apb_read(32'h10, 32'h0000_0301, 1'b0, "presc_ctrl");
        apb_read(32'h00, 32'd3, 1'b0, "presc_t15");
        apb_read(32'h00, 32'd4, 1'b0, "presc_t17");
`else
        apb_read(32'h00, 32'd11, 1'b0, "presc_t11");
        apb_read(32'h10, 32'h0000_0001, 1'b0, "presc_ctrl");
        apb_read(32'h00, 32'd15, 1'b0, "presc_t15");
        apb_read(32'h00, 32'd17, 1'b0, "presc_t17");
`endif
        apb_write(32'h10, 32'h0, 4'hF, 1'b0, "w_stop4");

        // Error responses change no state.
        apb_write(32'h00, 32'h0000_0055, 4'hF, 1'b0, "w_err_lo");
        apb_write(32'h04, 32'h0000_0000, 4'hF, 1'b0, "w_err_hi");
        apb_write(32'h14, 32'hFFFF_FFFF, 4'hF, 1'b1, "err_w_status");
        apb_write(32'h18, 32'h0000_1234, 4'hF, 1'b1, "err_w_18");
        apb_write(32'h01, 32'hFFFF_FFFF, 4'hF, 1'b1, "err_w_01");
        apb_write(32'h11, 32'h0000_0301, 4'hF, 1'b1, "err_w_11");
        apb_read(32'h18, 32'h0, 1'b1, "err_r_18");
        apb_read(32'h1C, 32'h0, 1'b1, "err_r_1c");
        apb_read(32'h02, 32'h0, 1'b1, "err_r_02");
        apb_read(32'h00, 32'h0000_0055, 1'b0, "err_keep_lo");
        apb_read(32'h04, 32'h0000_0000, 1'b0, "err_keep_hi");
        apb_read(32'h08, 32'h0000_0010, 1'b0, "err_keep_cmp_lo");
        apb_read(32'h0C, 32'h0000_0001, 1'b0, "err_keep_cmp_hi");
        apb_read(32'h10, 32'h0000_0000, 1'b0, "err_keep_ctrl");
        apb_read(32'h14, 32'h0000_0000, 1'b0, "err_keep_status");

        // Reset during the access phase aborts the transfer.
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
        apb.paddr = 32'h08; apb.pwdata = 32'h0; apb.pstrb = 4'hF;
        @(posedge clk_i); #1;
        apb.penable = 1'b1;
        #1;
        rst_ni = 1'b0;
        #1;
        check1("rst_abort_pready", apb.pready, 1'b0);
        check1("rst_abort_pslverr", apb.pslverr, 1'b0);
        @(posedge clk_i); #1;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        rst_ni = 1'b1;
        apb_read(32'h08, 32'hFFFF_FFFF, 1'b0, "rst_abort_cmp_lo");
        apb_read(32'h00, 32'h0000_0000, 1'b0, "rst_abort_mtime_lo");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
